// File: rtl/ahb_spi_display_ctrl_if.sv
// AHB-Lite slave-side signal bundle for ahb_spi_display_ctrl.
// The slave modport is used by the controller; the master modport is used by
// whatever drives the bus (decoder/CPU side or a testbench).
interface ahb_spi_display_ctrl_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport slave (
    input  HSEL,
    input  HREADY,
    input  HADDR,
    input  HTRANS,
    input  HWRITE,
    input  HWDATA,
    output HRDATA,
    output HREADYOUT
  );

  modport master (
    output HSEL,
    output HREADY,
    output HADDR,
    output HTRANS,
    output HWRITE,
    output HWDATA,
    input  HRDATA,
    input  HREADYOUT
  );
endinterface

// File: rtl/ahb_spi_display_ctrl.sv
// AHB-Lite slave SPI master for the seven-segment display.
// The CPU pushes 8/16-bit words into a TX FIFO; a frame sequencer shifts them
// out MSB-first (SS active low, SCLK idle high, display samples on SCLK rise)
// and captures spi_miso_i on every rising SCLK edge into RXDATA.
// Optional feature macro: SPI_IRQ_EN adds the spi_IRQ output and CTRL.irq_en.
module ahb_spi_display_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET  = 7
) (
  input  logic                  HCLK,
  input  logic                  reset,
  ahb_spi_display_ctrl_if.slave ahb,
  output logic                  spi_sclk_o,
  output logic                  spi_ss_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
`ifdef SPI_IRQ_EN
  ,
  output logic                  spi_IRQ
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] DIV_RESET_C = 8'(DIV_RESET);
  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  // ---------------------------------------------------------------- bus side
  logic        addr_vld_q;
  logic        addr_wr_q;
  logic [1:0]  addr_q;
  logic        wr_txdata_s;
  logic        wr_ctrl_s;
  logic        rd_status_s;
  logic [31:0] rdata_s;
  logic [31:0] status_s;
  logic [31:0] ctrl_s;

  // control / status registers
  logic [7:0]  clkdiv_q;
  logic        word16_q;
  logic        overflow_q;
  logic        irq_en_s;

  // FIFO
  logic [15:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          push_s;
  logic          pop_s;
  logic          ovf_set_s;
  logic [15:0]   head_s;

  // frame sequencer
  state_e      state_q;
  logic [7:0]  hcnt_q;
  logic [7:0]  div_q;
  logic [3:0]  bitcnt_q;
  logic [15:0] tx_sh_q;
  logic [15:0] rx_sh_q;
  logic [15:0] rxdata_q;
  logic        sclk_q;
  logic        ss_q;
  logic        mosi_q;
  logic        half_end_s;
  logic        busy_s;

  logic        unused_s;

  // Address phase capture; only a selected non-idle transfer opens a data phase.
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      addr_vld_q <= 1'b0;
      addr_wr_q  <= 1'b0;
      addr_q     <= 2'd0;
    end else if (ahb.HREADY) begin
      addr_vld_q <= ahb.HSEL & ahb.HTRANS[1];
      addr_wr_q  <= ahb.HWRITE;
      addr_q     <= ahb.HADDR[3:2];
    end else begin
      addr_vld_q <= addr_vld_q;
      addr_wr_q  <= addr_wr_q;
      addr_q     <= addr_q;
    end
  end

  assign wr_txdata_s = addr_vld_q & addr_wr_q & (addr_q == A_TXDATA);
  assign wr_ctrl_s   = addr_vld_q & addr_wr_q & (addr_q == A_CTRL);
  assign rd_status_s = addr_vld_q & ~addr_wr_q & (addr_q == A_STATUS);

  assign busy_s       = (state_q != ST_IDLE);
  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == CW'(FIFO_DEPTH));
  assign head_s       = fifo_q[rd_ptr_q];

  // A full FIFO still accepts a push when the sequencer pops in the same cycle.
  assign pop_s     = (state_q == ST_IDLE) & ~fifo_empty_s;
  assign push_s    = wr_txdata_s & (~fifo_full_s | pop_s);
  assign ovf_set_s = wr_txdata_s & fifo_full_s & ~pop_s;

  assign status_s = {23'h000000, 5'(count_q), overflow_q, fifo_full_s, fifo_empty_s, busy_s};
  assign ctrl_s   = {22'h000000, irq_en_s, word16_q, clkdiv_q};

  // Read data mux driven in the data phase from the registered address.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (addr_vld_q && !addr_wr_q) begin
      case (addr_q)
        A_TXDATA: rdata_s = {16'h0000, rxdata_q};
        A_STATUS: rdata_s = status_s;
        A_CTRL:   rdata_s = ctrl_s;
        default:  rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign ahb.HRDATA    = rdata_s;
  assign ahb.HREADYOUT = 1'b1;

  // CTRL fields and the sticky overflow flag (a new overflow wins over a clearing read).
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      clkdiv_q   <= DIV_RESET_C;
      word16_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        clkdiv_q <= ahb.HWDATA[7:0];
        word16_q <= ahb.HWDATA[8];
      end else begin
        clkdiv_q <= clkdiv_q;
        word16_q <= word16_q;
      end
      if (ovf_set_s) begin
        overflow_q <= 1'b1;
      end else if (rd_status_s) begin
        overflow_q <= 1'b0;
      end else begin
        overflow_q <= overflow_q;
      end
    end
  end

`ifdef SPI_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  // Interrupt enable bit and the registered "queue drained" level interrupt.
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        irq_en_q <= ahb.HWDATA[9];
      end else begin
        irq_en_q <= irq_en_q;
      end
      irq_q <= irq_en_q & fifo_empty_s & ~busy_s;
    end
  end

  assign irq_en_s = irq_en_q;
  assign spi_IRQ  = irq_q;
`else
  assign irq_en_s = 1'b0;
`endif

  // Next FIFO occupancy from the accepted push and the sequencer pop.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // TX FIFO storage and pointers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 16'h0000;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= ahb.HWDATA[15:0];
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign half_end_s = (hcnt_q == div_q);

  // Frame sequencer: pops a word, paces each half-period with hcnt and drives registered SPI lines.
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hcnt_q   <= 8'h00;
      div_q    <= 8'h00;
      bitcnt_q <= 4'h0;
      tx_sh_q  <= 16'h0000;
      rx_sh_q  <= 16'h0000;
      rxdata_q <= 16'h0000;
      sclk_q   <= 1'b1;
      ss_q     <= 1'b1;
      mosi_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sclk_q <= 1'b1;
          hcnt_q <= 8'h00;
          if (!fifo_empty_s) begin
            // clkdiv and word16 are frozen here for the whole frame.
            div_q   <= clkdiv_q;
            rx_sh_q <= 16'h0000;
            ss_q    <= 1'b0;
            state_q <= ST_SETUP;
            if (word16_q) begin
              bitcnt_q <= 4'd15;
              tx_sh_q  <= head_s;
              mosi_q   <= head_s[15];
            end else begin
              bitcnt_q <= 4'd7;
              tx_sh_q  <= {head_s[7:0], 8'h00};
              mosi_q   <= head_s[7];
            end
          end else begin
            ss_q   <= 1'b1;
            mosi_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (half_end_s) begin
            hcnt_q  <= 8'h00;
            sclk_q  <= 1'b0;
            state_q <= ST_LOW;
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        ST_LOW: begin
          if (half_end_s) begin
            // Rising SCLK: the display latches MOSI, we latch MISO.
            hcnt_q  <= 8'h00;
            sclk_q  <= 1'b1;
            rx_sh_q <= {rx_sh_q[14:0], spi_miso_i};
            state_q <= ST_HIGH;
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        ST_HIGH: begin
          if (half_end_s) begin
            hcnt_q <= 8'h00;
            if (bitcnt_q == 4'd0) begin
              state_q <= ST_HOLD;
            end else begin
              bitcnt_q <= bitcnt_q - 4'd1;
              tx_sh_q  <= {tx_sh_q[14:0], 1'b0};
              mosi_q   <= tx_sh_q[14];
              sclk_q   <= 1'b0;
              state_q  <= ST_LOW;
            end
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (half_end_s) begin
            hcnt_q   <= 8'h00;
            rxdata_q <= rx_sh_q;
            ss_q     <= 1'b1;
            mosi_q   <= 1'b1;
            state_q  <= ST_GAP;
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        ST_GAP: begin
          if (half_end_s) begin
            hcnt_q  <= 8'h00;
            state_q <= ST_IDLE;
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hcnt_q  <= 8'h00;
          sclk_q  <= 1'b1;
          ss_q    <= 1'b1;
          mosi_q  <= 1'b1;
        end
      endcase
    end
  end

  assign spi_sclk_o = sclk_q;
  assign spi_ss_o   = ss_q;
  assign spi_mosi_o = mosi_q;

  // Bus bits outside the decoded fields.
  assign unused_s = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA[31:9]};

endmodule

// File: tb/tb_ahb_spi_display_ctrl.sv
// Self-checking bench for ahb_spi_display_ctrl: register vectors from a table,
// directed frame sequences, and randomized frames checked against a frame-level
// reference (bits, length, SS-low time, received word).
`timescale 1ns/1ps
module tb_ahb_spi_display_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_RESET  = 7;
`ifdef SPI_IRQ_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_03FF;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_01FF;
`endif

  logic HCLK = 1'b0;
  logic reset;
  logic spi_sclk_o, spi_ss_o, spi_mosi_o;
  logic spi_miso_i;
`ifdef SPI_IRQ_EN
  logic spi_IRQ;
`endif

  ahb_spi_display_ctrl_if bus();

  ahb_spi_display_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_RESET(DIV_RESET)) dut (
    .HCLK       (HCLK),
    .reset      (reset),
    .ahb        (bus),
    .spi_sclk_o (spi_sclk_o),
    .spi_ss_o   (spi_ss_o),
    .spi_mosi_o (spi_mosi_o),
    .spi_miso_i (spi_miso_i)
`ifdef SPI_IRQ_EN
    ,
    .spi_IRQ    (spi_IRQ)
`endif
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] mosi;
    logic [15:0] miso;
    int          nbits;
    int          ss_cyc;
  } frame_t;

  typedef struct {
    logic [15:0] data;
    int          nbits;
    int          div;
  } exp_t;

  typedef struct {
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  frame_t      obs_q[$];
  exp_t        exp_q[$];
  frame_t      cur;
  logic        in_frame   = 1'b0;
  logic        miso_zero  = 1'b0;
  int          stray_edges = 0;
  logic [15:0] last_rx    = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ahb_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = {28'h0, a, 2'b00};
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d;
  endtask

  task automatic ahb_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = {28'h0, a, 2'b00};
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    d = bus.HRDATA;
  endtask

  task automatic expect_frame(input logic [15:0] d, input logic w16, input int div);
    exp_t e;
    e.data  = d;
    e.nbits = w16 ? 16 : 8;
    e.div   = div;
    exp_q.push_back(e);
  endtask

  task automatic wait_ss(input logic level, input int budget, input string name);
    int waited;
    waited = 0;
    while (spi_ss_o !== level && waited < budget) begin
      @(negedge HCLK);
      waited++;
    end
    check(name, {31'h0, spi_ss_o}, {31'h0, level});
  endtask

  // Compare every expected frame against what the line monitor saw.
  task automatic check_frames(input int budget);
    int          waited;
    exp_t        e;
    frame_t      o;
    logic [15:0] em;
    waited = 0;
    while (obs_q.size() < exp_q.size() && waited < budget) begin
      @(negedge HCLK);
      waited++;
    end
    check("frame_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) begin
        o  = obs_q.pop_front();
        em = (e.nbits == 16) ? e.data : {8'h00, e.data[7:0]};
        check("frame_mosi", {16'h0, o.mosi}, {16'h0, em});
        check("frame_bits", o.nbits, e.nbits);
        check("frame_ss_low", o.ss_cyc, (2 + 2 * e.nbits) * (e.div + 1));
        last_rx = o.miso;
      end
    end
    obs_q.delete();
  endtask

  // Line monitor and MISO source: record MOSI/MISO at every rising SCLK inside SS low.
  initial begin
    logic prev_sclk;
    prev_sclk  = 1'b1;
    spi_miso_i = 1'b1;
    forever begin
      @(negedge HCLK);
      if (reset) begin
        in_frame  = 1'b0;
        prev_sclk = 1'b1;
      end else begin
        if (!spi_ss_o) begin
          if (!in_frame) begin
            in_frame   = 1'b1;
            cur.mosi   = 16'h0;
            cur.miso   = 16'h0;
            cur.nbits  = 0;
            cur.ss_cyc = 0;
          end
          cur.ss_cyc++;
          if (!prev_sclk && spi_sclk_o) begin
            cur.mosi = {cur.mosi[14:0], spi_mosi_o};
            cur.miso = {cur.miso[14:0], spi_miso_i};
            cur.nbits++;
          end
        end else begin
          if (in_frame) begin
            obs_q.push_back(cur);
            in_frame = 1'b0;
          end
          if (!prev_sclk && spi_sclk_o) stray_edges++;
        end
        prev_sclk = spi_sclk_o;
      end
      spi_miso_i = miso_zero ? 1'b0 : ($urandom_range(1, 0) == 1);
    end
  end

  initial begin
    vec_t        vecs[7];
    logic [31:0] rd;
    logic [15:0] w;
    logic        w16;
    int          div;
    int          nw;
    int          waited;
    int          stray_base;

    vecs[0] = '{2'd2, 32'hFFFF_FFFF, 2'd2, 32'hFFFF_FFFF & CTRL_MASK};
    vecs[1] = '{2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000};
    vecs[2] = '{2'd2, 32'h0000_0155, 2'd2, 32'h0000_0155 & CTRL_MASK};
    vecs[3] = '{2'd2, 32'h1234_56AA, 2'd2, 32'h0000_02AA & CTRL_MASK};
    vecs[4] = '{2'd3, 32'hDEAD_BEEF, 2'd3, 32'h0000_0000};
    vecs[5] = '{2'd2, 32'h0000_0107, 2'd2, 32'h0000_0107};
    vecs[6] = '{2'd3, 32'hFFFF_FFFF, 2'd1, 32'h0000_0002};

    bus.HSEL = 1'b0; bus.HREADY = 1'b1; bus.HADDR = 32'h0; bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0; bus.HWDATA = 32'h0;
    reset = 1'b1;
    repeat (4) @(posedge HCLK);
    #3 reset = 1'b0;

    // Reset state
    check("rst_lines", {29'h0, spi_sclk_o, spi_ss_o, spi_mosi_o}, 32'h7);
    check("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check("rst_hrdata", bus.HRDATA, 32'h0);
    ahb_read(2'd1, rd); check("rst_status", rd, 32'h0000_0002);
    ahb_read(2'd2, rd); check("rst_ctrl", rd, 32'h0000_0107);
    ahb_read(2'd0, rd); check("rst_rxdata", rd, 32'h0000_0000);

    // Register table
    for (int i = 0; i < 7; i++) begin
      ahb_write(vecs[i].waddr, vecs[i].wdata);
      ahb_read(vecs[i].raddr, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // 16-bit frame 0xA5C3 at clkdiv 7
    ahb_write(2'd0, 32'hFFFF_A5C3);
    expect_frame(16'hA5C3, 1'b1, 7);
    wait_ss(1'b0, 50, "a5c3_ss_low");
    ahb_read(2'd1, rd); check("a5c3_busy_mid", rd, 32'h0000_0003);
    wait_ss(1'b1, 400, "a5c3_ss_high");
    ahb_read(2'd1, rd); check("a5c3_busy_gap", rd, 32'h0000_0003);
    repeat (10) @(posedge HCLK);
    ahb_read(2'd1, rd); check("a5c3_idle", rd, 32'h0000_0002);
    check_frames(100);
    ahb_read(2'd0, rd); check("a5c3_rxdata", rd, {16'h0, last_rx});

    // 8-bit frame at clkdiv 1, MISO tied low
    miso_zero = 1'b1;
    ahb_write(2'd2, 32'h0000_0001);
    ahb_write(2'd0, 32'h0000_01FF);
    expect_frame(16'h01FF, 1'b0, 1);
    check_frames(200);
    repeat (4) @(posedge HCLK);
    ahb_read(2'd0, rd); check("w8_rxdata_zero", rd, 32'h0000_0000);
    miso_zero = 1'b0;

    // Overflow: five words fill pipeline + FIFO, sixth is dropped
    ahb_write(2'd2, 32'h0000_0107);
    for (int k = 0; k < 5; k++) begin
      w = 16'h1111 * 16'(k + 1);
      ahb_write(2'd0, {16'h0, w});
      expect_frame(w, 1'b1, 7);
    end
    ahb_read(2'd1, rd); check("ovf_full_status", rd, 32'h0000_0045);
    ahb_write(2'd0, 32'h0000_EEEE);
    ahb_read(2'd1, rd); check("ovf_set", rd, 32'h0000_004D);
    ahb_read(2'd1, rd); check("ovf_cleared", rd, 32'h0000_0045);
    check_frames(3000);
    repeat (12) @(posedge HCLK);
    ahb_read(2'd1, rd); check("ovf_drained", rd, 32'h0000_0002);

    // Randomized frames against the frame-level reference
    for (int it = 0; it < 8; it++) begin
      div = $urandom_range(3, 0);
      w16 = ($urandom_range(1, 0) == 1);
      nw  = $urandom_range(FIFO_DEPTH, 1);
      ahb_write(2'd2, {23'h0, w16, 8'(div)});
      for (int k = 0; k < nw; k++) begin
        w = 16'($urandom);
        ahb_write(2'd0, {16'($urandom), w});
        expect_frame(w, w16, div);
      end
      check_frames(2000);
      repeat (div + 4) @(posedge HCLK);
      ahb_read(2'd0, rd); check("rand_rxdata", rd, {16'h0, last_rx});
      ahb_read(2'd1, rd); check("rand_idle", rd, 32'h0000_0002);
    end

    // Reset in the middle of a 16-bit frame
    ahb_write(2'd2, 32'h0000_0107);
    ahb_write(2'd0, 32'h0000_1234);
    ahb_write(2'd0, 32'h0000_5678);
    waited = 0;
    while (!(in_frame && cur.nbits == 9 && spi_sclk_o == 1'b0) && waited < 2000) begin
      @(negedge HCLK);
      waited++;
    end
    check("mid_pre_lines", {29'h0, spi_sclk_o, spi_ss_o, spi_mosi_o}, 32'h0);
    @(posedge HCLK);
    #3 reset = 1'b1;
    #1 check("mid_async_lines", {29'h0, spi_sclk_o, spi_ss_o, spi_mosi_o}, 32'h7);
    repeat (3) @(posedge HCLK);
    #3 reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    stray_base = stray_edges;
    repeat (100) @(posedge HCLK);
    check("mid_no_frames", obs_q.size(), 0);
    check("mid_no_sclk", stray_edges, stray_base);
    ahb_read(2'd1, rd); check("mid_status", rd, 32'h0000_0002);
    ahb_read(2'd2, rd); check("mid_ctrl", rd, 32'h0000_0107);

`ifdef SPI_IRQ_EN
    // Drained-queue interrupt
    ahb_write(2'd2, 32'h0000_0307);
    ahb_write(2'd0, 32'h0000_00AA);
    expect_frame(16'h00AA, 1'b1, 7);
    ahb_write(2'd0, 32'h0000_0055);
    expect_frame(16'h0055, 1'b1, 7);
    repeat (3) @(negedge HCLK);
    check("irq_low_busy", {31'h0, spi_IRQ}, 32'h0);
    check_frames(2000);
    waited = 0;
    while (spi_IRQ !== 1'b1 && waited < 30) begin
      @(negedge HCLK);
      waited++;
    end
    check("irq_rise", {31'h0, spi_IRQ}, 32'h1);
    ahb_write(2'd0, 32'h0000_0F0F);
    @(posedge HCLK);
    @(posedge HCLK); #1;
    check("irq_fall", {31'h0, spi_IRQ}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
